// File: rtl/quant_pkg.sv
// Shared definitions for the int8 quantize output packer.
// - Byte/word geometry constants.
// - Packed FIFO entry layout: data, keep, last.
// - Helper that builds a keep mask for the lanes 0..lane.
package quant_pkg;

    localparam int unsigned QBYTE_W    = 8;
    localparam int unsigned PACK_LANES = 4;
    localparam int unsigned PACK_W     = 32;
    localparam int unsigned ENTRY_W    = PACK_W + PACK_LANES + 1;

    typedef struct packed {
        logic [PACK_W-1:0]     data;
        logic [PACK_LANES-1:0] keep;
        logic                  last;
    } pack_entry_t;

    // Ones in lanes 0..lane: (2 << lane) - 1
    function automatic logic [PACK_LANES-1:0] lane_keep(input logic [1:0] lane);
        logic [4:0] m;
        m = (5'd2 << lane) - 5'd1;
        return m[3:0];
    endfunction

endpackage

// File: rtl/quant_sync_fifo.sv
// Parameterised synchronous FIFO with registered storage.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   push, din    write request and data; ignored when full unless popping
//   pop, dout    read request and head-of-queue data (ignored when empty)
//   full, empty  occupancy flags
// A push while full is accepted when a pop happens in the same cycle.
module quant_sync_fifo #(
    parameter int unsigned WIDTH = 37,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_q[AW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/quant_stream_packer.sv
// Packs the int8 quantize stream into 32-bit little-endian words with a
// byte-keep mask, queues them for the memory writer and counts saturated
// samples per frame.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_data/in_sat/in_last  upstream byte stream (no back-pressure)
//   out_valid/out_ready              packed word handshake
//   out_data/out_keep/out_last       packed word, byte k at [8k+7:8k]
//   sat_count, frame_done            saturations of last frame, update pulse
//   drop_err, clr_err                sticky overflow flag and its clear
module quant_stream_packer
    import quant_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [QBYTE_W-1:0]    in_data,
    input  logic                  in_sat,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACK_W-1:0]     out_data,
    output logic [PACK_LANES-1:0] out_keep,
    output logic                  out_last,
    output logic [CNT_W-1:0]      sat_count,
    output logic                  frame_done,
    output logic                  drop_err,
    input  logic                  clr_err
);

    logic [1:0]        lane_q, lane_d;
    logic [PACK_W-1:0] asm_q, asm_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  sat_count_q, sat_count_d;
    logic              frame_done_q, frame_done_d;
    logic              drop_err_q, drop_err_d;

    logic [PACK_W-1:0] merged;
    logic [CNT_W:0]    sat_sum;
    logic [CNT_W-1:0]  acc_inc;
    logic              word_done, pop, full, empty, drop;
    pack_entry_t       push_e, head_e;

    always_comb begin
        merged = asm_q;
        merged[8*lane_q +: 8] = in_data;

        word_done = in_valid && ((lane_q == 2'd3) || in_last);

        push_e.keep = lane_keep(lane_q);
        push_e.last = in_last;
        for (int unsigned i = 0; i < PACK_LANES; i++) begin
            push_e.data[8*i +: 8] = push_e.keep[i] ? merged[8*i +: 8] : 8'h00;
        end

        sat_sum = {1'b0, acc_q} + {{CNT_W{1'b0}}, in_sat};
        acc_inc = sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];

        lane_d       = lane_q;
        asm_d        = asm_q;
        acc_d        = acc_q;
        sat_count_d  = sat_count_q;
        frame_done_d = 1'b0;
        if (in_valid) begin
            lane_d = word_done ? 2'd0 : lane_q + 2'd1;
            asm_d  = word_done ? '0 : merged;
            acc_d  = in_last ? '0 : acc_inc;
            if (in_last) begin
                sat_count_d  = acc_inc;
                frame_done_d = 1'b1;
            end
        end

        pop  = !empty && out_ready;
        drop = word_done && full && !pop;
        if (drop)         drop_err_d = 1'b1;
        else if (clr_err) drop_err_d = 1'b0;
        else              drop_err_d = drop_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lane_q       <= '0;
            asm_q        <= '0;
            acc_q        <= '0;
            sat_count_q  <= '0;
            frame_done_q <= 1'b0;
            drop_err_q   <= 1'b0;
        end else begin
            lane_q       <= lane_d;
            asm_q        <= asm_d;
            acc_q        <= acc_d;
            sat_count_q  <= sat_count_d;
            frame_done_q <= frame_done_d;
            drop_err_q   <= drop_err_d;
        end
    end

    quant_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (word_done),
        .pop   (pop),
        .full  (full),
        .empty (empty),
        .din   (push_e),
        .dout  (head_e)
    );

    // Gate the head entry so the outputs read zero whenever nothing is queued
    assign out_valid  = !empty;
    assign out_data   = empty ? '0 : head_e.data;
    assign out_keep   = empty ? '0 : head_e.keep;
    assign out_last   = empty ? 1'b0 : head_e.last;
    assign sat_count  = sat_count_q;
    assign frame_done = frame_done_q;
    assign drop_err   = drop_err_q;

endmodule

// File: tb/tb_quant_stream_packer.sv
// Self-checking bench for quant_stream_packer: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_quant_stream_packer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int          SAT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, in_valid, in_sat, in_last, out_ready, clr_err;
    logic [7:0]       in_data;
    logic             out_valid, out_last, frame_done, drop_err;
    logic [31:0]      out_data;
    logic [3:0]       out_keep;
    logic [CNT_W-1:0] sat_count;

    int n_checks = 0;
    int n_fail   = 0;
    int drained  = 0;

    // Reference model state
    logic [7:0]  part[$];
    logic [36:0] mq[$];
    int          sat_acc = 0;
    int          exp_sat = 0;
    logic        exp_fd = 1'b0;
    logic        exp_drop = 1'b0;

    always #5 clk = ~clk;

    quant_stream_packer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_sat     (in_sat),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .sat_count  (sat_count),
        .frame_done (frame_done),
        .drop_err   (drop_err),
        .clr_err    (clr_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference update for one clock edge, using the inputs driven this cycle
    task automatic model_edge(input logic rst, v, input logic [7:0] d,
                              input logic s, l, rdy, clr);
        logic        pop, push, drop;
        logic [36:0] e;
        logic [31:0] w;
        logic [3:0]  k;
        if (!rst) begin
            part.delete(); mq.delete();
            sat_acc = 0; exp_sat = 0; exp_fd = 1'b0; exp_drop = 1'b0;
            return;
        end
        pop  = rdy && (mq.size() > 0);
        push = 1'b0;
        drop = 1'b0;
        exp_fd = 1'b0;
        if (v) begin
            part.push_back(d);
            sat_acc += s;
            if (l || part.size() == 4) begin
                w = '0;
                for (int i = 0; i < part.size(); i++) w[8*i +: 8] = part[i];
                k = 4'((1 << part.size()) - 1);
                e = {w, k, l};
                part.delete();
                push = 1'b1;
            end
            if (l) begin
                exp_sat = (sat_acc > SAT_MAX) ? SAT_MAX : sat_acc;
                exp_fd  = 1'b1;
                sat_acc = 0;
            end
        end
        if (pop) begin
            void'(mq.pop_front());
            drained++;
        end
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else drop = 1'b1;
        end
        if (drop)     exp_drop = 1'b1;
        else if (clr) exp_drop = 1'b0;
    endtask

    task automatic compare_all();
        logic [36:0] h;
        check("out_valid", 64'(out_valid), 64'(mq.size() > 0));
        if (mq.size() > 0) begin
            h = mq[0];
            check("out_data", 64'(out_data), 64'(h[36:5]));
            check("out_keep", 64'(out_keep), 64'(h[4:1]));
            check("out_last", 64'(out_last), 64'(h[0]));
        end
        check("sat_count",  64'(sat_count),  64'(exp_sat));
        check("frame_done", 64'(frame_done), 64'(exp_fd));
        check("drop_err",   64'(drop_err),   64'(exp_drop));
    endtask

    task automatic step(input logic rst, v, input logic [7:0] d,
                        input logic s, l, rdy, clr);
        @(negedge clk);
        rst_n = rst; in_valid = v; in_data = d; in_sat = s;
        in_last = l; out_ready = rdy; clr_err = clr;
        @(posedge clk);
        model_edge(rst, v, d, s, l, rdy, clr);
        #1;
        compare_all();
    endtask

    task automatic byte_in(input logic [7:0] d, input logic s, l, rdy);
        step(1'b1, 1'b1, d, s, l, rdy, 1'b0);
    endtask

    task automatic idle(input logic rdy, clr);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, rdy, clr);
    endtask

    logic [31:0] held;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sat = 1'b0;
        in_last = 1'b0; out_ready = 1'b0; clr_err = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_keep", 64'(out_keep), 64'h0);
        check("rst_last", 64'(out_last), 64'h0);

        // Full word, latency 1 cycle
        byte_in(8'h11, 1'b0, 1'b0, 1'b1);
        byte_in(8'h22, 1'b0, 1'b0, 1'b1);
        byte_in(8'h33, 1'b0, 1'b0, 1'b1);
        byte_in(8'h44, 1'b0, 1'b0, 1'b1);
        check("full_word_valid", 64'(out_valid), 64'h1);
        check("full_word_data", 64'(out_data), 64'h44332211);
        check("full_word_keep", 64'(out_keep), 64'hF);
        idle(1'b1, 1'b0);

        // Partial frame ending at lane 1
        byte_in(8'h7F, 1'b1, 1'b0, 1'b1);
        byte_in(8'h05, 1'b0, 1'b1, 1'b1);
        check("partial_data", 64'(out_data), 64'h0000057F);
        check("partial_keep", 64'(out_keep), 64'h3);
        check("partial_last", 64'(out_last), 64'h1);
        check("partial_sat", 64'(sat_count), 64'h1);
        check("partial_fd", 64'(frame_done), 64'h1);
        idle(1'b1, 1'b0);

        // Last at lane 0
        byte_in(8'h9C, 1'b0, 1'b1, 1'b1);
        check("lane0_keep", 64'(out_keep), 64'h1);
        idle(1'b1, 1'b0);

        // Overflow: 9 words into 8 entries with no drain
        for (int i = 0; i < 36; i++) byte_in(8'(i + 1), 1'b0, 1'b0, 1'b0);
        check("ovf_drop_err", 64'(drop_err), 64'h1);
        held = out_data;
        for (int i = 0; i < 3; i++) begin
            idle(1'b0, 1'b0);
            check("stall_hold", 64'(out_data), 64'(held));
        end
        idle(1'b0, 1'b1);
        check("clr_err", 64'(drop_err), 64'h0);

        // Full with simultaneous pop: word accepted, no drop
        byte_in(8'hA1, 1'b0, 1'b0, 1'b0);
        byte_in(8'hA2, 1'b0, 1'b0, 1'b0);
        byte_in(8'hA3, 1'b0, 1'b0, 1'b0);
        byte_in(8'hA4, 1'b0, 1'b0, 1'b1);
        check("full_pop_drop", 64'(drop_err), 64'h0);
        drained = 0;
        for (int i = 0; i < 12; i++) idle(1'b1, 1'b0);
        check("drain_count", 64'(drained), 64'd8);
        check("drain_empty", 64'(out_valid), 64'h0);

        // Saturating frame counter
        for (int i = 0; i < 20; i++) byte_in(8'(8'hC0 + i), 1'b1, (i == 19), 1'b1);
        check("sat_clamp", 64'(sat_count), 64'(SAT_MAX));
        check("sat_fd", 64'(frame_done), 64'h1);
        idle(1'b1, 1'b0);
        check("fd_pulse", 64'(frame_done), 64'h0);
        for (int i = 0; i < 3; i++) byte_in(8'(i), 1'b0, (i == 2), 1'b1);
        check("sat_zero", 64'(sat_count), 64'h0);
        idle(1'b1, 1'b0);

        // Reset mid-frame discards the partial word
        byte_in(8'hE1, 1'b1, 1'b0, 1'b1);
        byte_in(8'hE2, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        byte_in(8'hAA, 1'b0, 1'b0, 1'b1);
        byte_in(8'hBB, 1'b0, 1'b0, 1'b1);
        byte_in(8'hCC, 1'b0, 1'b0, 1'b1);
        byte_in(8'hDD, 1'b0, 1'b0, 1'b1);
        check("rst_mid_data", 64'(out_data), 64'hDDCCBBAA);
        check("rst_mid_keep", 64'(out_keep), 64'hF);
        idle(1'b1, 1'b0);

        // Randomized traffic with gaps, random back-pressure and clears
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 299) != 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 39) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/quant_stream_packer.md
Name: quant_stream_packer

Overview:
- Sits directly downstream of the int8 quantize pipeline and consumes its q_out / sat / out_valid stream.
- Packs consecutive 8-bit quantized values into 32-bit little-endian words, each with a byte-keep mask.
- Buffers packed words in a small FIFO. The upstream stage has no back-pressure, so the FIFO absorbs stalls on the output side.
- Drives a valid/ready output toward the memory writer. Also counts saturated samples per frame for calibration telemetry.

Parameters:
- DEPTH, 8, FIFO depth in packed words; power of two, ≥2
- CNT_W, 16, width of the per-frame saturation counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input byte valid; fed by upstream out_valid; no ready returned
- in_data  in  8  quantized value (upstream q_out)
- in_sat  in  1  saturation flag for this byte (upstream sat)
- in_last  in  1  last byte of frame; qualified by in_valid
- out_valid  out  1  packed word available
- out_ready  in  1  consumer accepts word
- out_data  out  32  packed word; byte k in bits [8k+7:8k]
- out_keep  out  4  per-byte valid mask
- out_last  out  1  word contains frame's final byte
- sat_count  out  CNT_W  saturations in the most recently completed frame
- frame_done  out  1  one-cycle pulse; sat_count updated this cycle
- drop_err  out  1  sticky; a packed word was lost to FIFO overflow
- clr_err  in  1  clears drop_err; set wins over clear in same cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): lane=0, assembly register=0, FIFO empty, sat accumulator=0.
  - Outputs at reset: out_valid=0, out_data=0, out_keep=0, out_last=0, sat_count=0, frame_done=0, drop_err=0.
  - Reset mid-frame discards the partial word and all queued words.
- Packing: 2-bit lane counter 0..3. On in_valid, in_data is written to byte[lane] of the assembly register.
  - Word completes when lane==3 or in_last=1.
  - On completion the word is pushed with keep = ones in lanes 0..lane; unused bytes are forced to 0.
  - After completion, lane←0 and the assembly register clears. Otherwise lane←lane+1.
  - in_last at lane 0 produces keep=4'b0001.
- Push timing: the word is pushed on the same edge as the completing byte. It is visible on out_valid the next cycle, so input-to-output latency is 1 cycle when the FIFO is empty.
- FIFO: registered, DEPTH entries; each entry holds data 32 bits, keep 4 bits, last 1 bit.
  - Pop occurs when out_valid && out_ready.
  - Push when full is accepted only if a pop occurs in the same cycle. Otherwise the word is dropped, drop_err←1, and the FIFO is unchanged.
  - Lane and statistics logic proceed regardless of a drop.
  - Simultaneous push and pop on an empty FIFO: the word is pushed and out_valid rises next cycle (no bypass).
- Output stability: while out_valid && !out_ready, out_data, out_keep and out_last hold. out_valid never drops without a pop.
- Saturation stats: accumulator adds in_sat on each in_valid and saturates at 2^CNT_W−1 (no wrap).
  - On the in_last byte: sat_count ← accumulator + in_sat (saturated), frame_done=1 for one cycle, accumulator←0.
- in_valid=0 cycles hold all packing state; gaps between bytes are legal.
- clr_err is ignored unless drop_err is set, and a new drop in the same cycle keeps drop_err=1.

Decomposition:
- Shared package quant_pkg holds:
  - constants QBYTE_W=8, PACK_LANES=4, PACK_W=32;
  - the FIFO entry layout (data, keep, last), with width PACK_W+PACK_LANES+1.
- One natural sub-module: quant_sync_fifo, a parameterised synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push, pop, full, empty, din, dout.
  - Reset is synchronous active-low.
- Lane counter, assembly register and saturation accumulator stay in quant_stream_packer.

Test Plan:
- Full word: bytes 0x11,0x22,0x33,0x44 on consecutive cycles with out_ready=1 → one word out_data=0x44332211, keep=4'hF, last=0, out_valid high 1 cycle after the 4th byte.
- Partial frame: 0x7F,0x05 (in_last on 2nd), in_sat=1,0 → out_data=0x0000057F, keep=4'h3, last=1; frame_done pulse with sat_count=1.
- Back-pressure/overflow: DEPTH=8, out_ready=0, 36 bytes without last → 8 words queued, 9th dropped, drop_err=1. Then out_ready=1 → exactly 8 words drained in order, data stable while stalled. Then clr_err=1 → drop_err=0.
- Full-with-pop: FIFO full, out_ready=1 on the same cycle a 4th byte arrives → word accepted, drop_err stays 0, count stays 8.
- Saturation counter: CNT_W=4, 20 bytes all in_sat=1 with last on 20th → sat_count=15, one frame_done; the next frame of 3 bytes with no sat → sat_count=0.
- Reset mid-frame: 2 bytes in, rst_n=0 one cycle, then 0xAA,0xBB,0xCC,0xDD → single word 0xDDCCBBAA, keep=4'hF; no stale bytes.
